// File: rtl/writeback_unit_pkg.sv
// Shared constants for the write-back stage: result sources, load funct3 codes,
// output-queue FSM states and small decode helpers for load accesses.
package writeback_unit_pkg;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MEM = 2'd1,
      SRC_PC4 = 2'd2,
      SRC_CSR = 2'd3
   } src_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } wb_state_e;

   // log2 of the access size in bytes; doubles collapse to words on a 32-bit datapath
   function automatic logic [1:0] access_size(input logic [2:0] funct3, input logic is64);
      logic [1:0] sz;
      case (funct3)
         F3_LB, F3_LBU: sz = 2'd0;
         F3_LH, F3_LHU: sz = 2'd1;
         F3_LW, F3_LWU: sz = 2'd2;
         F3_LD:         sz = is64 ? 2'd3 : 2'd2;
         default:       sz = 2'd2;
      endcase
      return sz;
   endfunction

   function automatic logic load_signed(input logic [2:0] funct3);
      return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) || (funct3 == F3_LD);
   endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Request, register-file write port and bypass signals of the write-back stage.
interface writeback_unit_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 64
);
   logic               i_valid;
   logic               o_ready;
   logic [1:0]         i_src_sel;
   logic [XLEN-1:0]    i_alu_out;
   logic [XLEN-1:0]    i_mem_out;
   logic [XLEN-1:0]    i_pc4;
   logic [XLEN-1:0]    i_csr_out;
   logic [2:0]         i_ld_funct3;
   logic [2:0]         i_addr_lo;
   logic [RADDR_W-1:0] i_rd_num;
   logic               i_rd_we;
   logic               o_rd_we;
   logic [RADDR_W-1:0] o_rd_num;
   logic [XLEN-1:0]    o_rd;
   logic               i_rf_ready;
   logic               o_fwd_valid;
   logic [RADDR_W-1:0] o_fwd_num;
   logic [XLEN-1:0]    o_fwd_data;
   logic               o_misalign;
   logic [CNT_W-1:0]   o_retire_cnt;

   modport master (
      output i_valid, i_src_sel, i_alu_out, i_mem_out, i_pc4, i_csr_out,
             i_ld_funct3, i_addr_lo, i_rd_num, i_rd_we, i_rf_ready,
      input  o_ready, o_rd_we, o_rd_num, o_rd, o_fwd_valid, o_fwd_num,
             o_fwd_data, o_misalign, o_retire_cnt
   );

   modport slave (
      input  i_valid, i_src_sel, i_alu_out, i_mem_out, i_pc4, i_csr_out,
             i_ld_funct3, i_addr_lo, i_rd_num, i_rd_we, i_rf_ready,
      output o_ready, o_rd_we, o_rd_num, o_rd, o_fwd_valid, o_fwd_num,
             o_fwd_data, o_misalign, o_retire_cnt
   );
endinterface

// File: rtl/writeback_unit_load_align.sv
// Extracts the addressed byte/half/word/double from the load data bus,
// right-justifies and extends it, and flags misaligned accesses.
module load_align
   import writeback_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mem_data,
   input  logic [2:0]      funct3,
   input  logic [2:0]      addr_lo,
   output logic [XLEN-1:0] data,
   output logic            misalign
);
   localparam int   OFFW = (XLEN == 64) ? 3 : 2;
   localparam logic IS64 = (XLEN == 64);

   logic [1:0]      size;
   logic            sgn;
   logic            top;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;

   assign size    = access_size(funct3, IS64);
   assign sgn     = load_signed(funct3);
   assign shifted = mem_data >> {addr_lo[OFFW-1:0], 3'b000};

   // mask keeps the accessed bytes; its complement is the sign-fill region
   always_comb begin
      mask     = '1;
      top      = shifted[XLEN-1];
      misalign = (addr_lo != 3'd0);
      case (size)
         2'd0: begin
            mask     = XLEN'(8'hFF);
            top      = shifted[7];
            misalign = 1'b0;
         end
         2'd1: begin
            mask     = XLEN'(16'hFFFF);
            top      = shifted[15];
            misalign = addr_lo[0];
         end
         2'd2: begin
            mask     = XLEN'(32'hFFFF_FFFF);
            top      = shifted[31];
            misalign = (addr_lo[1:0] != 2'd0);
         end
         default: ;
      endcase
      data = (shifted & mask) | ((sgn && top) ? ~mask : '0);
   end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: selects/aligns the result and queues it in a two-entry
// output+skid buffer in front of the register-file write port.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 64
) (
   input logic            i_clk,
   input logic            i_rst_n,
   writeback_unit_if.slave bus
);
   wb_state_e          state;
   logic               ready_q;
   logic               out_we;
   logic               out_mis;
   logic [RADDR_W-1:0] out_num;
   logic [XLEN-1:0]    out_data;
   logic               skid_we;
   logic               skid_mis;
   logic [RADDR_W-1:0] skid_num;
   logic [XLEN-1:0]    skid_data;
   logic [CNT_W-1:0]   retire_cnt;

   logic [XLEN-1:0]    mem_data;
   logic               mem_mis;
   logic [XLEN-1:0]    in_data;
   logic               in_mis;
   logic               in_we;
   logic               accept;
   logic               drain;
   logic               fwd_valid;
   logic [RADDR_W-1:0] fwd_num;
   logic [XLEN-1:0]    fwd_data;

   load_align #(.XLEN(XLEN)) u_load_align (
      .mem_data (bus.i_mem_out),
      .funct3   (bus.i_ld_funct3),
      .addr_lo  (bus.i_addr_lo),
      .data     (mem_data),
      .misalign (mem_mis)
   );

   always_comb begin
      in_data = bus.i_alu_out;
      in_mis  = 1'b0;
      case (src_sel_e'(bus.i_src_sel))
         SRC_MEM: begin
            in_data = mem_data;
            in_mis  = mem_mis;
         end
         SRC_PC4: in_data = bus.i_pc4;
         SRC_CSR: in_data = bus.i_csr_out;
         default: ;
      endcase
   end

   assign in_we  = bus.i_rd_we && (bus.i_rd_num != '0) && !in_mis;
   assign accept = bus.i_valid && ready_q;
   // entries that do not write never wait on the register file
   assign drain  = (state != ST_EMPTY) && (!out_we || bus.i_rf_ready);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= ST_EMPTY;
         ready_q    <= 1'b1;
         out_we     <= 1'b0;
         out_mis    <= 1'b0;
         out_num    <= '0;
         out_data   <= '0;
         skid_we    <= 1'b0;
         skid_mis   <= 1'b0;
         skid_num   <= '0;
         skid_data  <= '0;
         retire_cnt <= '0;
      end else begin
         if (drain)
            retire_cnt <= retire_cnt + CNT_W'(1);
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  out_we   <= in_we;
                  out_mis  <= in_mis;
                  out_num  <= bus.i_rd_num;
                  out_data <= in_data;
                  state    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  out_we   <= in_we;
                  out_mis  <= in_mis;
                  out_num  <= bus.i_rd_num;
                  out_data <= in_data;
               end else if (accept) begin
                  skid_we   <= in_we;
                  skid_mis  <= in_mis;
                  skid_num  <= bus.i_rd_num;
                  skid_data <= in_data;
                  ready_q   <= 1'b0;
                  state     <= ST_TWO;
               end else if (drain) begin
                  out_we  <= 1'b0;
                  out_mis <= 1'b0;
                  state   <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  out_we   <= skid_we;
                  out_mis  <= skid_mis;
                  out_num  <= skid_num;
                  out_data <= skid_data;
                  ready_q  <= 1'b1;
                  state    <= ST_ONE;
               end
            end
            default: begin
               ready_q <= 1'b1;
               out_we  <= 1'b0;
               out_mis <= 1'b0;
               state   <= ST_EMPTY;
            end
         endcase
      end
   end

   // bypass the youngest pending write; the skid entry is younger than the output
   always_comb begin
      fwd_valid = 1'b0;
      fwd_num   = '0;
      fwd_data  = '0;
      if ((state == ST_TWO) && skid_we) begin
         fwd_valid = 1'b1;
         fwd_num   = skid_num;
         fwd_data  = skid_data;
      end else if (out_we) begin
         fwd_valid = 1'b1;
         fwd_num   = out_num;
         fwd_data  = out_data;
      end
   end

   assign bus.o_ready      = ready_q;
   assign bus.o_rd_we      = out_we;
   assign bus.o_rd_num     = out_num;
   assign bus.o_rd         = out_data;
   assign bus.o_misalign   = out_mis;
   assign bus.o_fwd_valid  = fwd_valid;
   assign bus.o_fwd_num    = fwd_num;
   assign bus.o_fwd_data   = fwd_data;
   assign bus.o_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector tables, multi-cycle corner cases and
// a randomized run against a queue-based reference of the two-entry buffer.
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_unit_if #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) bus ();
   writeback_unit_if #(.XLEN(64), .RADDR_W(5), .CNT_W(4))  bus64 ();

   writeback_unit #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
   writeback_unit #(.XLEN(64), .RADDR_W(5), .CNT_W(4)) dut64 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus64));

   typedef struct {
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [2:0]  addr;
      logic [31:0] val;
      logic [4:0]  rd;
      logic        rdwe;
      logic        exp_we;
      logic        exp_mis;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic [2:0]  f3;
      logic [2:0]  addr;
      logic        exp_we;
      logic        exp_mis;
      logic [63:0] exp_rd;
   } vec64_t;

   typedef struct {
      logic        we;
      logic [4:0]  num;
      logic [63:0] data;
      logic        mis;
   } ent_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [63:0] exp_ret;
   vec_t        tbl[14];
   vec64_t      tbl64[9];
   ent_t        q[$];
   ent_t        new_e;
   logic        acc, drn, e_we, e_mis, fv;
   logic [4:0]  fn;
   logic [63:0] fd;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_main();
      bus.i_valid = 1'b0; bus.i_src_sel = 2'd0; bus.i_alu_out = '0; bus.i_mem_out = '0;
      bus.i_pc4 = '0; bus.i_csr_out = '0; bus.i_ld_funct3 = 3'd0; bus.i_addr_lo = 3'd0;
      bus.i_rd_num = '0; bus.i_rd_we = 1'b0; bus.i_rf_ready = 1'b1;
   endtask

   task automatic idle_64();
      bus64.i_valid = 1'b0; bus64.i_src_sel = 2'd0; bus64.i_alu_out = '0; bus64.i_mem_out = '0;
      bus64.i_pc4 = '0; bus64.i_csr_out = '0; bus64.i_ld_funct3 = 3'd0; bus64.i_addr_lo = 3'd0;
      bus64.i_rd_num = '0; bus64.i_rd_we = 1'b0; bus64.i_rf_ready = 1'b1;
   endtask

   // unselected sources carry distinct junk so a wrong mux leg shows up
   task automatic apply_stimulus(input vec_t v);
      bus.i_src_sel   = v.sel;
      bus.i_ld_funct3 = v.f3;
      bus.i_addr_lo   = v.addr;
      bus.i_alu_out   = (v.sel == 2'd0) ? v.val : 32'hA1A1_A1A1;
      bus.i_mem_out   = (v.sel == 2'd1) ? v.val : 32'hB2B2_B2B2;
      bus.i_pc4       = (v.sel == 2'd2) ? v.val : 32'hC3C3_C3C3;
      bus.i_csr_out   = (v.sel == 2'd3) ? v.val : 32'hD4D4_D4D4;
      bus.i_rd_num    = v.rd;
      bus.i_rd_we     = v.rdwe;
      bus.i_valid     = 1'b1;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
      bus.i_src_sel = 2'd0; bus.i_alu_out = val; bus.i_rd_num = rd;
      bus.i_rd_we = 1'b1; bus.i_valid = 1'b1;
   endtask

   // reference result: assemble the load byte by byte from the bus, then extend
   function automatic ent_t ref_entry(input logic [1:0] sel, input logic [2:0] f3,
                                      input logic [2:0] addr, input logic [63:0] alu,
                                      input logic [63:0] mem, input logic [63:0] pc4,
                                      input logic [63:0] csr, input logic [4:0] rd,
                                      input logic rdwe, input int xbytes);
      ent_t e;
      int   nb;
      int   off;
      bit   sgn;
      e.mis  = 1'b0;
      e.num  = rd;
      e.data = '0;
      case (sel)
         2'd0: e.data = alu;
         2'd2: e.data = pc4;
         2'd3: e.data = csr;
         default: begin
            nb = 1 << int'(f3[1:0]);
            if (nb > xbytes) nb = 4;
            sgn   = (f3 < 3'd4);
            e.mis = (int'(addr) % nb) != 0;
            off   = int'(addr) % xbytes;
            for (int b = 0; b < 8; b++) begin
               if (b < nb) begin
                  if (off + b < xbytes) e.data[8*b +: 8] = mem[8*(off+b) +: 8];
               end else if (sgn && e.data[8*nb-1]) begin
                  e.data[8*b +: 8] = 8'hFF;
               end
            end
         end
      endcase
      if (xbytes == 4) e.data[63:32] = '0;
      e.we = rdwe && (rd != 5'd0) && !e.mis;
      return e;
   endfunction

   initial begin
      tbl[0]  = '{2'd1, 3'b000, 3'd1, 32'h0000_80FF, 5'd5,  1'b1, 1'b1, 1'b0, 32'hFFFF_FF80};
      tbl[1]  = '{2'd1, 3'b100, 3'd1, 32'h0000_80FF, 5'd6,  1'b1, 1'b1, 1'b0, 32'h0000_0080};
      tbl[2]  = '{2'd1, 3'b001, 3'd2, 32'h8001_7FFE, 5'd7,  1'b1, 1'b1, 1'b0, 32'hFFFF_8001};
      tbl[3]  = '{2'd1, 3'b101, 3'd2, 32'h8001_7FFE, 5'd8,  1'b1, 1'b1, 1'b0, 32'h0000_8001};
      tbl[4]  = '{2'd1, 3'b010, 3'd0, 32'hDEAD_BEEF, 5'd9,  1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
      tbl[5]  = '{2'd1, 3'b101, 3'd3, 32'h1234_5678, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[6]  = '{2'd0, 3'b000, 3'd0, 32'h0000_1234, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{2'd2, 3'b000, 3'd0, 32'h0000_0104, 5'd1,  1'b1, 1'b1, 1'b0, 32'h0000_0104};
      tbl[8]  = '{2'd3, 3'b000, 3'd0, 32'hCAFE_F00D, 5'd31, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
      tbl[9]  = '{2'd1, 3'b010, 3'd2, 32'h1111_2222, 5'd11, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[10] = '{2'd1, 3'b011, 3'd4, 32'h1122_3344, 5'd12, 1'b1, 1'b1, 1'b0, 32'h1122_3344};
      tbl[11] = '{2'd1, 3'b110, 3'd0, 32'h8000_0000, 5'd13, 1'b1, 1'b1, 1'b0, 32'h8000_0000};
      tbl[12] = '{2'd1, 3'b000, 3'd3, 32'h7F00_0000, 5'd14, 1'b1, 1'b1, 1'b0, 32'h0000_007F};
      tbl[13] = '{2'd0, 3'b000, 3'd0, 32'h0000_5555, 5'd3,  1'b0, 1'b0, 1'b0, 32'h0};

      tbl64[0] = '{3'b011, 3'd0, 1'b1, 1'b0, 64'h8877_6655_4433_2211};
      tbl64[1] = '{3'b010, 3'd4, 1'b1, 1'b0, 64'hFFFF_FFFF_8877_6655};
      tbl64[2] = '{3'b110, 3'd4, 1'b1, 1'b0, 64'h0000_0000_8877_6655};
      tbl64[3] = '{3'b000, 3'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF88};
      tbl64[4] = '{3'b101, 3'd6, 1'b1, 1'b0, 64'h0000_0000_0000_8877};
      tbl64[5] = '{3'b001, 3'd2, 1'b1, 1'b0, 64'h0000_0000_0000_4433};
      tbl64[6] = '{3'b011, 3'd4, 1'b0, 1'b1, 64'h0};
      tbl64[7] = '{3'b010, 3'd6, 1'b0, 1'b1, 64'h0};
      tbl64[8] = '{3'b100, 3'd5, 1'b1, 1'b0, 64'h0000_0000_0000_0066};

      idle_main();
      idle_64();
      rst_n = 1'b0;
      step();
      step();
      check_output("rst_ready", bus.o_ready, 1);
      check_output("rst_rd_we", bus.o_rd_we, 0);
      check_output("rst_rd_num", bus.o_rd_num, 0);
      check_output("rst_rd", bus.o_rd, 0);
      check_output("rst_fwd_valid", bus.o_fwd_valid, 0);
      check_output("rst_fwd_num", bus.o_fwd_num, 0);
      check_output("rst_fwd_data", bus.o_fwd_data, 0);
      check_output("rst_misalign", bus.o_misalign, 0);
      check_output("rst_retire", bus.o_retire_cnt, 0);
      rst_n = 1'b1;
      step();
      check_output("post_rst_ready", bus.o_ready, 1);
      exp_ret = '0;

      for (int i = 0; i < 14; i++) begin
         apply_stimulus(tbl[i]);
         step();
         bus.i_valid = 1'b0;
         check_output($sformatf("tbl%0d_rd_we", i), bus.o_rd_we, tbl[i].exp_we);
         check_output($sformatf("tbl%0d_misalign", i), bus.o_misalign, tbl[i].exp_mis);
         check_output($sformatf("tbl%0d_fwd_valid", i), bus.o_fwd_valid, tbl[i].exp_we);
         if (tbl[i].exp_we) begin
            check_output($sformatf("tbl%0d_rd_num", i), bus.o_rd_num, tbl[i].rd);
            check_output($sformatf("tbl%0d_rd", i), bus.o_rd, tbl[i].exp_rd);
         end
         step();
         exp_ret++;
         check_output($sformatf("tbl%0d_retire", i), bus.o_retire_cnt, exp_ret);
         check_output($sformatf("tbl%0d_drained", i), bus.o_rd_we | bus.o_misalign, 0);
      end

      // stalled register file: third request must be refused
      bus.i_rf_ready = 1'b0;
      drive_alu(5'd1, 32'h111);
      step();
      check_output("stall_a_ready", bus.o_ready, 1);
      check_output("stall_a_rd", bus.o_rd, 32'h111);
      check_output("stall_a_fwd_num", bus.o_fwd_num, 1);
      drive_alu(5'd2, 32'h222);
      step();
      check_output("stall_b_ready", bus.o_ready, 0);
      check_output("stall_b_rd_held", bus.o_rd, 32'h111);
      check_output("stall_b_fwd_num", bus.o_fwd_num, 2);
      check_output("stall_b_fwd_data", bus.o_fwd_data, 32'h222);
      drive_alu(5'd3, 32'h333);
      step();
      check_output("stall_c_ready", bus.o_ready, 0);
      check_output("stall_c_rd_num", bus.o_rd_num, 1);
      check_output("stall_c_fwd_data", bus.o_fwd_data, 32'h222);
      check_output("stall_c_retire", bus.o_retire_cnt, exp_ret);
      bus.i_valid = 1'b0;
      bus.i_rf_ready = 1'b1;
      step();
      exp_ret++;
      check_output("drain_a_rd_we", bus.o_rd_we, 1);
      check_output("drain_a_rd_num", bus.o_rd_num, 2);
      check_output("drain_a_rd", bus.o_rd, 32'h222);
      check_output("drain_a_ready", bus.o_ready, 1);
      check_output("drain_a_fwd_num", bus.o_fwd_num, 2);
      check_output("drain_a_retire", bus.o_retire_cnt, exp_ret);
      step();
      exp_ret++;
      check_output("drain_b_rd_we", bus.o_rd_we, 0);
      check_output("drain_b_fwd_valid", bus.o_fwd_valid, 0);
      check_output("drain_b_retire", bus.o_retire_cnt, exp_ret);
      step();
      check_output("no_c_rd_we", bus.o_rd_we, 0);
      check_output("no_c_retire", bus.o_retire_cnt, exp_ret);

      // reset while both entries are held
      bus.i_rf_ready = 1'b0;
      drive_alu(5'd4, 32'h444);
      step();
      drive_alu(5'd5, 32'h555);
      step();
      check_output("two_ready", bus.o_ready, 0);
      bus.i_valid = 1'b0;
      rst_n = 1'b0;
      step();
      check_output("rst2_rd_we", bus.o_rd_we, 0);
      check_output("rst2_rd", bus.o_rd, 0);
      check_output("rst2_rd_num", bus.o_rd_num, 0);
      check_output("rst2_fwd_valid", bus.o_fwd_valid, 0);
      check_output("rst2_fwd_data", bus.o_fwd_data, 0);
      check_output("rst2_retire", bus.o_retire_cnt, 0);
      check_output("rst2_ready", bus.o_ready, 1);
      rst_n = 1'b1;
      bus.i_rf_ready = 1'b1;
      step();
      check_output("rst2_after_rd_we", bus.o_rd_we, 0);
      check_output("rst2_after_retire", bus.o_retire_cnt, 0);

      // randomized traffic against the queue reference
      q.delete();
      exp_ret = '0;
      for (int c = 0; c < 400; c++) begin
         bus.i_valid     = ($urandom_range(0, 9) < 6);
         bus.i_src_sel   = 2'($urandom_range(0, 3));
         bus.i_ld_funct3 = 3'($urandom_range(0, 6));
         bus.i_addr_lo   = 3'($urandom_range(0, 7));
         bus.i_alu_out   = $urandom;
         bus.i_mem_out   = $urandom;
         bus.i_pc4       = $urandom;
         bus.i_csr_out   = $urandom;
         bus.i_rd_num    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.i_rd_we     = ($urandom_range(0, 9) != 0);
         bus.i_rf_ready  = ($urandom_range(0, 9) < 6);
         check_output("rnd_ready", bus.o_ready, q.size() < 2);
         acc = bus.i_valid && (q.size() < 2);
         drn = (q.size() > 0) && (!q[0].we || bus.i_rf_ready);
         new_e = ref_entry(bus.i_src_sel, bus.i_ld_funct3, bus.i_addr_lo,
                           64'(bus.i_alu_out), 64'(bus.i_mem_out), 64'(bus.i_pc4),
                           64'(bus.i_csr_out), bus.i_rd_num, bus.i_rd_we, 4);
         step();
         if (drn) begin
            void'(q.pop_front());
            exp_ret++;
         end
         if (acc) q.push_back(new_e);
         e_we  = (q.size() > 0) ? q[0].we : 1'b0;
         e_mis = (q.size() > 0) ? q[0].mis : 1'b0;
         check_output("rnd_rd_we", bus.o_rd_we, e_we);
         check_output("rnd_misalign", bus.o_misalign, e_mis);
         if (e_we) begin
            check_output("rnd_rd_num", bus.o_rd_num, q[0].num);
            check_output("rnd_rd", bus.o_rd, q[0].data);
         end
         fv = 1'b0; fn = '0; fd = '0;
         for (int k = q.size() - 1; k >= 0; k--) begin
            if (!fv && q[k].we) begin
               fv = 1'b1; fn = q[k].num; fd = q[k].data;
            end
         end
         check_output("rnd_fwd_valid", bus.o_fwd_valid, fv);
         if (fv) begin
            check_output("rnd_fwd_num", bus.o_fwd_num, fn);
            check_output("rnd_fwd_data", bus.o_fwd_data, fd);
         end
         check_output("rnd_retire", bus.o_retire_cnt, exp_ret);
      end
      idle_main();

      // 64-bit datapath loads
      bus64.i_src_sel = 2'd1;
      bus64.i_mem_out = 64'h8877_6655_4433_2211;
      bus64.i_alu_out = 64'hA1A1_A1A1_A1A1_A1A1;
      bus64.i_rd_num  = 5'd7;
      bus64.i_rd_we   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus64.i_ld_funct3 = tbl64[i].f3;
         bus64.i_addr_lo   = tbl64[i].addr;
         bus64.i_valid     = 1'b1;
         step();
         bus64.i_valid = 1'b0;
         check_output($sformatf("x64_%0d_rd_we", i), bus64.o_rd_we, tbl64[i].exp_we);
         check_output($sformatf("x64_%0d_misalign", i), bus64.o_misalign, tbl64[i].exp_mis);
         if (tbl64[i].exp_we)
            check_output($sformatf("x64_%0d_rd", i), bus64.o_rd, tbl64[i].exp_rd);
         step();
      end

      // 4-bit retire counter wraps after 16 retirements
      idle_64();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus64.i_src_sel = 2'd0;
      bus64.i_alu_out = 64'h1234;
      bus64.i_rd_num  = 5'd0;
      bus64.i_rd_we   = 1'b1;
      bus64.i_valid   = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         check_output($sformatf("wrap_cnt_%0d", k), bus64.o_retire_cnt, 64'((k - 1) % 16));
      end
      bus64.i_valid = 1'b0;
      step();
      check_output("wrap_to_zero", bus64.o_retire_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
